// File: rtl/heap_sort_pkg.sv
// Shared types and helpers for the heap sorter.
package heap_sort_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        BUILD,
        EXTRACT,
        DONE
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/heap_sort_cmp.sv
// Parent / two-children compare for one sift-down step.
// Returns the index the parent should swap with, or the parent index itself
// when the heap property already holds. Children outside the heap bound are
// ignored. Strict compares keep equal keys in place so sifting terminates.
module heap_sort_cmp #(
    parameter int element_size = 9,
    parameter int IW           = 10,
    parameter int MIN_MAX      = 1
) (
    input  logic [element_size-1:0] p_val_i,
    input  logic [element_size-1:0] l_val_i,
    input  logic [element_size-1:0] r_val_i,
    input  logic [IW-1:0]           p_idx_i,
    input  logic [IW-1:0]           l_idx_i,
    input  logic [IW-1:0]           r_idx_i,
    input  logic [IW-1:0]           hsize_i,
    output logic [IW-1:0]           tgt_idx_o,
    output logic                    swap_o
);

    // Ascending output needs a max-heap, descending a min-heap.
    function automatic logic better(input logic [element_size-1:0] a,
                                    input logic [element_size-1:0] b);
        if (MIN_MAX != 0) return a > b;
        else              return a < b;
    endfunction

    logic [IW-1:0]           best_idx;
    logic [element_size-1:0] best_val;

    // pick the extreme of parent and in-bound children
    always_comb begin
        best_idx = p_idx_i;
        best_val = p_val_i;
        if ((l_idx_i < hsize_i) && better(l_val_i, best_val)) begin
            best_idx = l_idx_i;
            best_val = l_val_i;
        end
        if ((r_idx_i < hsize_i) && better(r_val_i, best_val)) begin
            best_idx = r_idx_i;
        end
        tgt_idx_o = best_idx;
        swap_o    = (best_idx != p_idx_i);
    end

endmodule

// File: rtl/heap_sort.sv
// In-place heap sort of a packed array, one compare/swap level per cycle.
// Optional macro HEAP_SORT_ASSERT_EN adds simulation assertions on the
// result ordering and busy/done exclusivity, plus the swap trace when
// debug is nonzero.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start
// LOAD    | capture array_i into storage
// BUILD   | heapify: sift-down nodes array_size/2-1 .. 0
// EXTRACT | swap root with last heap slot, shrink, sift-down root
// DONE    | publish storage to array_o, pulse done
module heap_sort
    import heap_sort_pkg::*;
#(
    parameter int array_size   = 256,
    parameter int element_size = 9,
    parameter int MIN_MAX      = 1,
    parameter int debug        = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [element_size*array_size-1:0] array_i,
    output logic [element_size*array_size-1:0] array_o,
    output logic                               busy,
    output logic                               done
);

    localparam int LG    = clog2(array_size);
    localparam int AW    = (LG > 0) ? LG : 1;
    // wide enough for child indices up to 2*array_size
    localparam int IW    = LG + 2;
    localparam int NODE0 = (array_size >= 2) ? (array_size / 2 - 1) : 0;

    state_t                            state_q, state_d;
    logic [IW-1:0]                     node_q, node_d;
    logic [IW-1:0]                     cur_q, cur_d;
    logic [IW-1:0]                     hsize_q, hsize_d;
    logic                              sift_q, sift_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;
    logic [element_size-1:0]           mem_q [array_size];
    logic [element_size*array_size-1:0] out_q;

    logic                    load_en, out_en, swap_en;
    logic [AW-1:0]           swap_a, swap_b;
    logic [element_size-1:0] a_val, b_val;
    logic [IW-1:0]           l_idx, r_idx, last_idx, tgt_idx;
    logic [element_size-1:0] p_val, l_val, r_val;
    logic                    do_swap;

    assign l_idx    = (cur_q << 1) + IW'(1);
    assign r_idx    = (cur_q << 1) + IW'(2);
    assign last_idx = hsize_q - IW'(1);

    assign p_val = mem_q[cur_q[AW-1:0]];
    assign l_val = (l_idx < IW'(array_size)) ? mem_q[l_idx[AW-1:0]] : '0;
    assign r_val = (r_idx < IW'(array_size)) ? mem_q[r_idx[AW-1:0]] : '0;
    assign a_val = mem_q[swap_a];
    assign b_val = mem_q[swap_b];

    heap_sort_cmp #(
        .element_size (element_size),
        .IW           (IW),
        .MIN_MAX      (MIN_MAX)
    ) u_cmp (
        .p_val_i   (p_val),
        .l_val_i   (l_val),
        .r_val_i   (r_val),
        .p_idx_i   (cur_q),
        .l_idx_i   (l_idx),
        .r_idx_i   (r_idx),
        .hsize_i   (hsize_q),
        .tgt_idx_o (tgt_idx),
        .swap_o    (do_swap)
    );

    // next-state and datapath control
    always_comb begin
        state_d = state_q;
        node_d  = node_q;
        cur_d   = cur_q;
        hsize_d = hsize_q;
        sift_d  = sift_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load_en = 1'b0;
        out_en  = 1'b0;
        swap_en = 1'b0;
        swap_a  = cur_q[AW-1:0];
        swap_b  = tgt_idx[AW-1:0];
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    busy_d  = 1'b1;
                end
            end
            LOAD: begin
                load_en = 1'b1;
                node_d  = IW'(NODE0);
                cur_d   = IW'(NODE0);
                hsize_d = IW'(array_size);
                sift_d  = 1'b0;
                if (array_size > 1) state_d = BUILD;
                else                state_d = DONE;
            end
            BUILD: begin
                if (do_swap) begin
                    swap_en = 1'b1;
                    cur_d   = tgt_idx;
                end else if (node_q == '0) begin
                    state_d = EXTRACT;
                end else begin
                    node_d = node_q - IW'(1);
                    cur_d  = node_q - IW'(1);
                end
            end
            EXTRACT: begin
                if (sift_q) begin
                    if (do_swap) begin
                        swap_en = 1'b1;
                        cur_d   = tgt_idx;
                    end else begin
                        sift_d = 1'b0;
                    end
                end else if (hsize_q <= IW'(1)) begin
                    state_d = DONE;
                end else begin
                    swap_en = 1'b1;
                    swap_a  = '0;
                    swap_b  = last_idx[AW-1:0];
                    hsize_d = last_idx;
                    cur_d   = '0;
                    sift_d  = 1'b1;
                end
            end
            DONE: begin
                out_en  = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            node_q  <= '0;
            cur_q   <= '0;
            hsize_q <= '0;
            sift_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            node_q  <= node_d;
            cur_q   <= cur_d;
            hsize_q <= hsize_d;
            sift_q  <= sift_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // element storage: bulk load or a two-slot swap per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < array_size; k++) mem_q[k] <= '0;
        end else if (load_en) begin
            for (int k = 0; k < array_size; k++)
                mem_q[k] <= array_i[k*element_size +: element_size];
        end else if (swap_en) begin
            mem_q[swap_a] <= b_val;
            mem_q[swap_b] <= a_val;
        end
    end

    // result register, only updated alongside the done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else if (out_en) begin
            for (int k = 0; k < array_size; k++)
                out_q[k*element_size +: element_size] <= mem_q[k];
        end
    end

    assign array_o = out_q;
    assign busy    = busy_q;
    assign done    = done_q;

    if (debug != 0) begin : g_trace
`ifdef HEAP_SORT_ASSERT_EN
        // swap trace
        always @(posedge clk) begin
            if (!rst && swap_en) $display("heap_sort swap [%0d] <-> [%0d]", swap_a, swap_b);
        end
`endif
    end

`ifdef HEAP_SORT_ASSERT_EN
    // result ordering on done and busy/done exclusivity
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(busy_q && done_q)) else $error("heap_sort: busy and done both high");
            if (done_q) begin
                for (int k = 1; k < array_size; k++) begin
                    if (MIN_MAX != 0)
                        assert (out_q[k*element_size +: element_size] >= out_q[(k-1)*element_size +: element_size])
                            else $error("heap_sort: ascending order broken at %0d", k);
                    else
                        assert (out_q[k*element_size +: element_size] <= out_q[(k-1)*element_size +: element_size])
                            else $error("heap_sort: descending order broken at %0d", k);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_heap_sort.sv
// Directed bench for heap_sort: four instances (4-element ascending and
// descending, default 256-element, single element) sharing one clock.
module tb_heap_sort;

    localparam int ES       = 9;
    localparam int NB       = 256;
    localparam int BOUND4   = 2*4*(2+2)+8;
    localparam int BOUND256 = 2*256*(8+2)+8;
    localparam int BOUND1   = 2*1*(0+2)+8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_a, start_a, busy_a, done_a;
    logic [4*ES-1:0]  in_a, out_a;
    logic             rst_d, start_d, busy_d, done_d;
    logic [4*ES-1:0]  in_d, out_d;
    logic             rst_r, start_r, busy_r, done_r;
    logic [NB*ES-1:0] in_r, out_r;
    logic             rst_s, start_s, busy_s, done_s;
    logic [ES-1:0]    in_s, out_s;

    heap_sort #(.array_size(4), .element_size(ES), .MIN_MAX(1), .debug(0)) u_asc4 (
        .clk(clk), .rst(rst_a), .start(start_a), .array_i(in_a),
        .array_o(out_a), .busy(busy_a), .done(done_a));

    heap_sort #(.array_size(4), .element_size(ES), .MIN_MAX(0), .debug(0)) u_dsc4 (
        .clk(clk), .rst(rst_d), .start(start_d), .array_i(in_d),
        .array_o(out_d), .busy(busy_d), .done(done_d));

    heap_sort u_def (
        .clk(clk), .rst(rst_r), .start(start_r), .array_i(in_r),
        .array_o(out_r), .busy(busy_r), .done(done_r));

    heap_sort #(.array_size(1), .element_size(ES), .MIN_MAX(1), .debug(0)) u_one (
        .clk(clk), .rst(rst_s), .start(start_s), .array_i(in_s),
        .array_o(out_s), .busy(busy_s), .done(done_s));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Random 256-element ascending sort on u_def, checked by histogram and order.
    task automatic run_rand(input string tag);
        int hin[512];
        int hout[512];
        int bad, viol, ndone, cyc;
        logic [NB*ES-1:0] cap, res;
        for (int v = 0; v < 512; v++) begin
            hin[v]  = 0;
            hout[v] = 0;
        end
        for (int k = 0; k < NB; k++) in_r[k*ES +: ES] = ES'($urandom_range(0, 511));
        cap = in_r;
        @(negedge clk); start_r = 1'b1;
        @(negedge clk); start_r = 1'b0;
        check({tag, "_busy"}, busy_r, 1);
        ndone = 0; cyc = 0; res = '0;
        for (int c = 2; c <= BOUND256 + 20 && ndone == 0; c++) begin
            @(negedge clk);
            if (c == 2) in_r = ~cap;
            if (done_r) begin
                ndone++;
                cyc = c;
                res = out_r;
            end
        end
        check({tag, "_done"}, ndone, 1);
        check({tag, "_in_bound"}, (cyc > 0 && cyc <= BOUND256), 1);
        for (int k = 0; k < NB; k++) begin
            hin[int'(cap[k*ES +: ES])]++;
            hout[int'(res[k*ES +: ES])]++;
        end
        bad = 0;
        for (int v = 0; v < 512; v++) if (hin[v] != hout[v]) bad++;
        viol = 0;
        for (int k = 1; k < NB; k++) if (res[k*ES +: ES] < res[(k-1)*ES +: ES]) viol++;
        check({tag, "_perm_bins"}, bad, 0);
        check({tag, "_order_viol"}, viol, 0);
        @(negedge clk);
        check({tag, "_busy_after"}, busy_r, 0);
    endtask

    initial begin
        int ndone_a, ndone_d, cyc_a, cyc_d, ndone, cyc;
        logic [4*ES-1:0] res_a, res_d;
        logic [ES-1:0]   res_s;

        rst_a = 1'b1; rst_d = 1'b1; rst_r = 1'b1; rst_s = 1'b1;
        start_a = 1'b0; start_d = 1'b0; start_r = 1'b0; start_s = 1'b0;
        in_a = '0; in_d = '0; in_r = '0; in_s = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_out_a", out_a, 0);
        check("rst_out_d", out_d, 0);
        check("rst_out_def_zero", (out_r == '0), 1);
        check("rst_busy_def", busy_r, 0);
        check("rst_out_one", out_s, 0);
        rst_a = 1'b0; rst_d = 1'b0; rst_r = 1'b0; rst_s = 1'b0;

        // {0x1FF,0x000,0x055,0x055} sorted both ways in parallel
        in_a = {9'h055, 9'h055, 9'h000, 9'h1FF};
        in_d = {9'h055, 9'h055, 9'h000, 9'h1FF};
        @(negedge clk); start_a = 1'b1; start_d = 1'b1;
        @(negedge clk); start_a = 1'b0; start_d = 1'b0;
        check("asc4_busy", busy_a, 1);
        check("dsc4_busy", busy_d, 1);
        ndone_a = 0; ndone_d = 0; cyc_a = 0; cyc_d = 0; res_a = '0; res_d = '0;
        for (int c = 2; c <= BOUND4 + 10; c++) begin
            @(negedge clk);
            if (c == 2) begin
                in_a = '1;
                in_d = '1;
            end
            if (done_a) begin ndone_a++; cyc_a = c; res_a = out_a; end
            if (done_d) begin ndone_d++; cyc_d = c; res_d = out_d; end
        end
        check("asc4_ndone", ndone_a, 1);
        check("dsc4_ndone", ndone_d, 1);
        check("asc4_in_bound", (cyc_a > 0 && cyc_a <= BOUND4), 1);
        check("dsc4_in_bound", (cyc_d > 0 && cyc_d <= BOUND4), 1);
        check("asc4_result", res_a, {9'h1FF, 9'h055, 9'h055, 9'h000});
        check("dsc4_result", res_d, {9'h000, 9'h055, 9'h055, 9'h1FF});
        check("asc4_hold", out_a, {9'h1FF, 9'h055, 9'h055, 9'h000});
        check("asc4_idle_busy", busy_a, 0);

        // second start while busy is ignored; result from first capture
        in_a = {9'h007, 9'h1AA, 9'h003, 9'h010};
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        ndone_a = 0; res_a = '0;
        for (int c = 2; c <= BOUND4 + 20; c++) begin
            @(negedge clk);
            if (c == 2) in_a = {4{9'h1F0}};
            if (c == 4) start_a = 1'b1;
            if (c == 5) start_a = 1'b0;
            if (done_a) begin ndone_a++; res_a = out_a; end
        end
        check("busy_start_ndone", ndone_a, 1);
        check("busy_start_result", res_a, {9'h1AA, 9'h010, 9'h007, 9'h003});

        // reset wins over a simultaneous start
        rst_a = 1'b1; start_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0; start_a = 1'b0;
        @(negedge clk);
        check("rst_prio_busy", busy_a, 0);
        check("rst_prio_out", out_a, 0);

        // single element passes straight through
        in_s = 9'h0AB;
        @(negedge clk); start_s = 1'b1;
        @(negedge clk); start_s = 1'b0;
        ndone = 0; cyc = 0; res_s = '0;
        for (int c = 2; c <= BOUND1 + 5; c++) begin
            @(negedge clk);
            if (done_s) begin ndone++; cyc = c; res_s = out_s; end
        end
        check("one_ndone", ndone, 1);
        check("one_in_bound", (cyc > 0 && cyc <= BOUND1), 1);
        check("one_result", res_s, 9'h0AB);

        // full random sort, then abort one mid-BUILD, then sort again
        run_rand("rand1");
        for (int k = 0; k < NB; k++) in_r[k*ES +: ES] = ES'($urandom_range(0, 511));
        @(negedge clk); start_r = 1'b1;
        @(negedge clk); start_r = 1'b0;
        ndone = 0;
        repeat (5) begin
            @(negedge clk);
            if (done_r) ndone++;
        end
        check("abort_busy_pre", busy_r, 1);
        rst_r = 1'b1;
        @(negedge clk);
        check("abort_busy", busy_r, 0);
        check("abort_done", done_r, 0);
        check("abort_out_zero", (out_r == '0), 1);
        rst_r = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done_r) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run_rand("rand2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
